// File: rtl/fft_in_framer.sv
// fft_in_framer
//   Front end of the CORDIC FFT. Collects a serial stream of complex W-bit
//   samples into N-sample frames using two ping-pong banks. A completed bank
//   is presented in parallel on frame_re/frame_im and held there until the
//   consumer acknowledges it with frame_ack.
//
//   Compile-time option: define BIT_REVERSE_EN to store each frame in
//   bit-reversed slot order (decimation-in-time input ordering). When it is
//   left undefined, sample k lands in slot k.
//
// Ports
//   clk, rst           clock (rising edge), async active-high reset
//   in_valid/in_ready  sample handshake; in_re/in_im are the sample, in_sof
//                      marks the first sample of a frame
//   frame_valid        a complete frame is on frame_re/frame_im (slot k at
//                      bits [k*W +: W])
//   frame_ack          consumer has taken the presented frame
//   frame_cnt          number of frames completed, wraps at 8 bits
//   sof_err            one-cycle pulse when in_sof discards a partial frame
module fft_in_framer #(
    parameter int N     = 64,
    parameter int LOG2N = 6,
    parameter int W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_re,
    input  logic [W-1:0]   in_im,
    input  logic           in_sof,
    output logic           frame_valid,
    input  logic           frame_ack,
    output logic [N*W-1:0] frame_re,
    output logic [N*W-1:0] frame_im,
    output logic [7:0]     frame_cnt,
    output logic           sof_err
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // Storage: [bank][slot][bit]. Because the array is packed, a single bank
    // already has the required output layout (slot k at bits [k*W +: W]).
    logic [1:0][N-1:0][W-1:0] bank_re_q, bank_im_q;

    logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic             sof_err_q, sof_err_d;

    logic             accept, sof_restart, complete, ack;
    logic [LOG2N-1:0] wr_pos, wr_addr;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    always_comb begin
        in_ready    = !bank_full_q[wr_sel_q] && !rst;
        accept      = in_valid && in_ready;
        // A start-of-frame mid-frame restarts at slot 0; that sample becomes
        // the first of a new frame, so it never completes the old one.
        sof_restart = accept && in_sof && (wr_idx_q != '0);
        complete    = accept && !sof_restart && (wr_idx_q == LAST_IDX);
        ack         = frame_ack && bank_full_q[rd_sel_q];

        wr_pos = sof_restart ? '0 : wr_idx_q;
`ifdef BIT_REVERSE_EN
        wr_addr = bitrev(wr_pos);
`else
        wr_addr = wr_pos;
`endif

        wr_idx_d = wr_idx_q;
        if (sof_restart)  wr_idx_d = LOG2N'(1);
        else if (accept)  wr_idx_d = wr_idx_q + 1'b1;  // wraps to 0 at N-1

        wr_sel_d    = wr_sel_q ^ complete;
        rd_sel_d    = rd_sel_q ^ ack;
        frame_cnt_d = frame_cnt_q + {7'd0, complete};
        sof_err_d   = sof_restart;

        // Completion and ack always touch different banks (the write bank is
        // never full when it completes), so both can apply on one edge.
        bank_full_d = bank_full_q;
        if (complete) bank_full_d[wr_sel_q] = 1'b1;
        if (ack)      bank_full_d[rd_sel_q] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_re_q   <= '0;
            bank_im_q   <= '0;
            wr_idx_q    <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            bank_full_q <= 2'b00;
            frame_cnt_q <= '0;
            sof_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                bank_re_q[wr_sel_q][wr_addr] <= in_re;
                bank_im_q[wr_sel_q][wr_addr] <= in_im;
            end
            wr_idx_q    <= wr_idx_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            bank_full_q <= bank_full_d;
            frame_cnt_q <= frame_cnt_d;
            sof_err_q   <= sof_err_d;
        end
    end

    // The presented bank cannot be written while it is full, so the outputs
    // stay stable until the ack.
    assign frame_valid = bank_full_q[rd_sel_q];
    assign frame_re    = bank_re_q[rd_sel_q];
    assign frame_im    = bank_im_q[rd_sel_q];
    assign frame_cnt   = frame_cnt_q;
    assign sof_err     = sof_err_q;

endmodule
